bindct_2d_processor: RTL and testbench

- 8x8 forward 2D BinDCT-C5 engine for the JPEG compression path.
- Accepts one 8-pixel image row per handshake and emits eight 128-bit coefficient words per block; the downstream quantiser consumes these words.
- Built from a row 1D transform (8-bit in, 12-bit out), a ping-pong pair of 8x8 transpose buffers with a control FSM, and a column 1D transform (12-bit in, 16-bit out).

---
 rtl/bindct_2d_processor_if.sv | 27 ++
 rtl/bindct_2d_processor.sv | 268 ++++++++++++++++++++++++++
 tb/tb_bindct_2d_processor.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bindct_2d_processor_if.sv
// Row-in / coefficient-out bus of the 2D BinDCT engine.
//   BD_inputready  : one-cycle strobe, BD_readdata holds one 8-pixel row
//   BD_readdata    : 8 x signed 8-bit pixels, pixel k in bits [8k+7:8k]
//   BD_outputready : one-cycle strobe, BD_writedata holds one coefficient word
//   BD_writedata   : 8 x signed 16-bit coefficients, lane k in bits [16k+15:16k]
// The slave modport is the engine side; the master modport is the row source
// and coefficient sink.
interface bindct_2d_processor_if;
  logic         BD_inputready;
  logic [63:0]  BD_readdata;
  logic         BD_outputready;
  logic [127:0] BD_writedata;

  modport master (
    output BD_inputready,
    output BD_readdata,
    input  BD_outputready,
    input  BD_writedata
  );

  modport slave (
    input  BD_inputready,
    input  BD_readdata,
    output BD_outputready,
    output BD_writedata
  );
endinterface

// File: rtl/bindct_2d_processor.sv
// Forward 8x8 2D BinDCT-C5 engine.
// A row transform (8-bit pixels -> 12-bit) feeds a ping-pong pair of 8x8
// transpose buffers (TM_A / TM_B). A full buffer is read one column per cycle
// into a column transform (12-bit -> 16-bit). Output word j carries C[u][j]
// in lane u. Sustains one row per cycle; first word 7 cycles and last word
// 14 cycles after the 8th row strobe.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of bindct_2d_processor_if (row in, coefficients out)
module bindct_2d_processor (
  input logic                  clk,
  input logic                  reset,
  bindct_2d_processor_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int MID_W  = 12;
  localparam int COEF_W = 16;
  localparam int IW     = 20;  // wide enough for every intermediate of either pass

  typedef logic signed [IW-1:0] iw_t;
  // e0 is the least significant lane so lane k sits at bits [IW*k +: IW]
  typedef struct packed { iw_t e7, e6, e5, e4, e3, e2, e1, e0; } oct_t;
  // State carried from the even/first-lifting stage into the odd finish
  typedef struct packed { iw_t y0, y2, y4, y6, a4, a6, a7, t5; } mid_t;
  typedef enum logic { RD_IDLE, RD_BUSY } rd_state_t;

  function automatic iw_t mul3(input iw_t v);
    return (v <<< 1) + v;
  endfunction

  function automatic iw_t mul5(input iw_t v);
    return (v <<< 2) + v;
  endfunction

  function automatic iw_t mul7(input iw_t v);
    return (v <<< 3) - v;
  endfunction

  function automatic oct_t ext_pix(input logic [8*DATA_W-1:0] d);
    oct_t x;
    for (int k = 0; k < 8; k++) x[IW*k +: IW] = iw_t'($signed(d[DATA_W*k +: DATA_W]));
    return x;
  endfunction

  function automatic oct_t ext_mid(input logic [8*MID_W-1:0] d);
    oct_t x;
    for (int k = 0; k < 8; k++) x[IW*k +: IW] = iw_t'($signed(d[MID_W*k +: MID_W]));
    return x;
  endfunction

  // Ranges guarantee no overflow, so narrowing is a plain truncation
  function automatic logic [8*MID_W-1:0] trunc_mid(input oct_t y);
    logic [8*MID_W-1:0] r;
    for (int k = 0; k < 8; k++) r[MID_W*k +: MID_W] = y[IW*k +: MID_W];
    return r;
  endfunction

  function automatic logic [8*COEF_W-1:0] trunc_coef(input oct_t y);
    logic [8*COEF_W-1:0] r;
    for (int k = 0; k < 8; k++) r[COEF_W*k +: COEF_W] = y[IW*k +: COEF_W];
    return r;
  endfunction

  function automatic oct_t bfly(input oct_t x);
    oct_t a;
    a.e0 = x.e0 + x.e7;
    a.e1 = x.e1 + x.e6;
    a.e2 = x.e2 + x.e5;
    a.e3 = x.e3 + x.e4;
    a.e4 = x.e3 - x.e4;
    a.e5 = x.e2 - x.e5;
    a.e6 = x.e1 - x.e6;
    a.e7 = x.e0 - x.e7;
    return a;
  endfunction

  function automatic mid_t lift1(input oct_t a);
    mid_t m;
    iw_t  a0, a1, a2, a3, a5, a6, b0, b1, b2, b3, y0, y6;
    a0 = a.e0; a1 = a.e1; a2 = a.e2; a3 = a.e3; a5 = a.e5; a6 = a.e6;
    b0 = a0 + a3;
    b1 = a1 + a2;
    b2 = a1 - a2;
    b3 = a0 - a3;
    y0 = b0 + b1;
    y6 = (b3 >>> 1) - b2;
    m.y0 = y0;
    m.y4 = (y0 >>> 1) - b1;
    m.y6 = y6;
    m.y2 = b3 - (y6 >>> 1);
    m.a4 = a.e4;
    m.a6 = a6;
    m.a7 = a.e7;
    m.t5 = a5 - (mul3(a6) >>> 3);
    return m;
  endfunction

  function automatic oct_t lift2(input mid_t m);
    oct_t y;
    iw_t  a4, a6, a7, t5, t6, t5b, f4, f5, f6, f7, y1, y3, y5, y7;
    a4 = m.a4; a6 = m.a6; a7 = m.a7; t5 = m.t5;
    t6  = a6 + (mul5(t5) >>> 3);
    t5b = (mul3(t6) >>> 3) - t5;
    f4  = a4 + t5b;
    f5  = a4 - t5b;
    f6  = a7 - t6;
    f7  = a7 + t6;
    y7  = (f7 >>> 3) - f4;
    y1  = f7 - (y7 >>> 3);
    y5  = f5 + (mul7(f6) >>> 3);
    y3  = f6 - (y5 >>> 1);
    y.e0 = m.y0; y.e1 = y1; y.e2 = m.y2; y.e3 = y3;
    y.e4 = m.y4; y.e5 = y5; y.e6 = m.y6; y.e7 = y7;
    return y;
  endfunction

  // Row and column pipelines
  logic                row_vld_p0_q, row_vld_p0_d, row_vld_p1_q, row_vld_p1_d;
  logic                row_vld_p2_q, row_vld_p2_d;
  oct_t                row_a_p0_q, row_a_p0_d;
  mid_t                row_m_p1_q, row_m_p1_d;
  logic [8*MID_W-1:0]  row_y_p2_q, row_y_p2_d;
  logic                col_vld_p0_q, col_vld_p0_d, col_vld_p1_q, col_vld_p1_d;
  logic                col_vld_p2_q, col_vld_p2_d;
  oct_t                col_a_p0_q, col_a_p0_d;
  mid_t                col_m_p1_q, col_m_p1_d;
  logic [8*COEF_W-1:0] col_y_p2_q, col_y_p2_d;

  // Transpose control and storage
  logic                wr_sel_q, wr_sel_d;       // 0: TM_A receives rows
  logic [2:0]          wr_cnt_q, wr_cnt_d;
  logic                full_a_q, full_a_d, full_b_q, full_b_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic                rd_ptr_q, rd_ptr_d;       // 0: TM_A is next/active read
  logic [2:0]          rd_cnt_q, rd_cnt_d;
  logic                rd_vld_q, rd_vld_d;
  logic [8*MID_W-1:0]  rd_data_q, rd_data_d;
  logic [MID_W-1:0]    tm_a_q [8][8];
  logic [MID_W-1:0]    tm_a_d [8][8];
  logic [MID_W-1:0]    tm_b_q [8][8];
  logic [MID_W-1:0]    tm_b_d [8][8];
  logic                wr_fire, wr_last, rd_active, rd_last;

  always_comb begin
    row_vld_p0_d = bus.BD_inputready;
    row_vld_p1_d = row_vld_p0_q;
    row_vld_p2_d = row_vld_p1_q;
    row_a_p0_d   = row_a_p0_q;
    row_m_p1_d   = row_m_p1_q;
    row_y_p2_d   = row_y_p2_q;
    col_vld_p0_d = rd_vld_q;
    col_vld_p1_d = col_vld_p0_q;
    col_vld_p2_d = col_vld_p1_q;
    col_a_p0_d   = col_a_p0_q;
    col_m_p1_d   = col_m_p1_q;
    col_y_p2_d   = col_y_p2_q;
    // p0: butterfly
    if (bus.BD_inputready) row_a_p0_d = bfly(ext_pix(bus.BD_readdata));
    if (rd_vld_q)          col_a_p0_d = bfly(ext_mid(rd_data_q));
    // p1: even part and first odd lifting step
    if (row_vld_p0_q) row_m_p1_d = lift1(row_a_p0_q);
    if (col_vld_p0_q) col_m_p1_d = lift1(col_a_p0_q);
    // p2: remaining odd lifting, narrowed to the stage output width
    if (row_vld_p1_q) row_y_p2_d = trunc_mid(lift2(row_m_p1_q));
    if (col_vld_p1_q) col_y_p2_d = trunc_coef(lift2(col_m_p1_q));
  end

  always_comb begin
    tm_a_d    = tm_a_q;
    tm_b_d    = tm_b_q;
    rd_data_d = rd_data_q;
    wr_fire   = row_vld_p2_q;
    wr_last   = wr_fire && (wr_cnt_q == 3'd7);
    wr_cnt_d  = wr_fire ? wr_cnt_q + 3'd1 : wr_cnt_q;
    wr_sel_d  = wr_sel_q ^ wr_last;
    rd_active = (rd_state_q == RD_BUSY);
    rd_last   = rd_active && (rd_cnt_q == 3'd7);
    rd_cnt_d  = rd_active ? rd_cnt_q + 3'd1 : 3'd0;
    rd_ptr_d  = rd_ptr_q ^ rd_last;
    rd_vld_d  = rd_active;

    full_a_d = full_a_q;
    full_b_d = full_b_q;
    if (wr_last && !wr_sel_q) full_a_d = 1'b1;
    if (wr_last &&  wr_sel_q) full_b_d = 1'b1;
    if (rd_last && !rd_ptr_q) full_a_d = 1'b0;
    if (rd_last &&  rd_ptr_q) full_b_d = 1'b0;

    // A buffer filling on this edge starts its read on the very next cycle,
    // and a finishing read hands straight over to the other full buffer.
    rd_state_d = rd_state_q;
    if (!rd_active || rd_last)
      rd_state_d = (rd_ptr_d ? full_b_d : full_a_d) ? RD_BUSY : RD_IDLE;

    if (wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        if (wr_sel_q) tm_b_d[wr_cnt_q][k] = row_y_p2_q[MID_W*k +: MID_W];
        else          tm_a_d[wr_cnt_q][k] = row_y_p2_q[MID_W*k +: MID_W];
      end
    end

    // Read stage: column rd_cnt of the active buffer, row u lands in lane u
    if (rd_active) begin
      for (int u = 0; u < 8; u++)
        rd_data_d[MID_W*u +: MID_W] = rd_ptr_q ? tm_b_q[u][rd_cnt_q] : tm_a_q[u][rd_cnt_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_vld_p0_q <= 1'b0;
      row_vld_p1_q <= 1'b0;
      row_vld_p2_q <= 1'b0;
      row_a_p0_q   <= '0;
      row_m_p1_q   <= '0;
      row_y_p2_q   <= '0;
      col_vld_p0_q <= 1'b0;
      col_vld_p1_q <= 1'b0;
      col_vld_p2_q <= 1'b0;
      col_a_p0_q   <= '0;
      col_m_p1_q   <= '0;
      col_y_p2_q   <= '0;
      wr_sel_q     <= 1'b0;
      wr_cnt_q     <= 3'd0;
      full_a_q     <= 1'b0;
      full_b_q     <= 1'b0;
      rd_state_q   <= RD_IDLE;
      rd_ptr_q     <= 1'b0;
      rd_cnt_q     <= 3'd0;
      rd_vld_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      row_vld_p0_q <= row_vld_p0_d;
      row_vld_p1_q <= row_vld_p1_d;
      row_vld_p2_q <= row_vld_p2_d;
      row_a_p0_q   <= row_a_p0_d;
      row_m_p1_q   <= row_m_p1_d;
      row_y_p2_q   <= row_y_p2_d;
      col_vld_p0_q <= col_vld_p0_d;
      col_vld_p1_q <= col_vld_p1_d;
      col_vld_p2_q <= col_vld_p2_d;
      col_a_p0_q   <= col_a_p0_d;
      col_m_p1_q   <= col_m_p1_d;
      col_y_p2_q   <= col_y_p2_d;
      wr_sel_q     <= wr_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      full_a_q     <= full_a_d;
      full_b_q     <= full_b_d;
      rd_state_q   <= rd_state_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Buffer contents are only ever read after being written, so no reset
  always_ff @(posedge clk) begin
    tm_a_q <= tm_a_d;
    tm_b_q <= tm_b_d;
  end

  assign bus.BD_outputready = col_vld_p2_q;
  assign bus.BD_writedata   = col_y_p2_q;

endmodule

// File: tb/tb_bindct_2d_processor.sv
module tb_bindct_2d_processor;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   last_edge;
  int   n_checks = 0;
  int   n_pass = 0;

  bindct_2d_processor_if bus ();

  bindct_2d_processor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef int vec8_t[8];
  typedef int blk_t[8][8];

  logic [127:0] got_w[$];
  int           got_c[$];

  always @(negedge clk)
    if (bus.BD_outputready === 1'b1) begin
      got_w.push_back(bus.BD_writedata);
      got_c.push_back(cyc);
    end

  // ---------------- reference model ----------------
  function automatic int sext(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  function automatic void dct1d(input vec8_t x, output vec8_t y);
    int a0, a1, a2, a3, a4, a5, a6, a7, b0, b1, b2, b3;
    int t5, t6, t5b, f4, f5, f6, f7;
    a0 = x[0] + x[7]; a1 = x[1] + x[6]; a2 = x[2] + x[5]; a3 = x[3] + x[4];
    a4 = x[3] - x[4]; a5 = x[2] - x[5]; a6 = x[1] - x[6]; a7 = x[0] - x[7];
    b0 = a0 + a3; b1 = a1 + a2; b2 = a1 - a2; b3 = a0 - a3;
    y[0] = b0 + b1;
    y[4] = (y[0] >>> 1) - b1;
    y[6] = (b3 >>> 1) - b2;
    y[2] = b3 - (y[6] >>> 1);
    t5  = a5 - ((3 * a6) >>> 3);
    t6  = a6 + ((5 * t5) >>> 3);
    t5b = ((3 * t6) >>> 3) - t5;
    f4 = a4 + t5b; f5 = a4 - t5b; f6 = a7 - t6; f7 = a7 + t6;
    y[7] = (f7 >>> 3) - f4;
    y[1] = f7 - (y[7] >>> 3);
    y[5] = f5 + ((7 * f6) >>> 3);
    y[3] = f6 - (y[5] >>> 1);
  endfunction

  function automatic void model2d(input blk_t p, output blk_t c);
    blk_t  t;
    vec8_t v, o;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) v[k] = p[r][k];
      dct1d(v, o);
      for (int k = 0; k < 8; k++) t[r][k] = sext(o[k], 12);
    end
    for (int j = 0; j < 8; j++) begin
      for (int u = 0; u < 8; u++) v[u] = t[u][j];
      dct1d(v, o);
      for (int u = 0; u < 8; u++) c[u][j] = sext(o[u], 16);
    end
  endfunction

  function automatic logic [127:0] exp_word(input blk_t c, input int j);
    logic [127:0] e;
    int           v;
    for (int u = 0; u < 8; u++) begin
      v = c[u][j];
      e[16*u +: 16] = v[15:0];
    end
    return e;
  endfunction

  function automatic int lane(input logic [127:0] w, input int u);
    return sext(int'(w[16*u +: 16]), 16);
  endfunction

  function automatic blk_t const_blk(input int v);
    blk_t p;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) p[r][k] = v;
    return p;
  endfunction

  function automatic blk_t rand_blk();
    blk_t p;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) p[r][k] = int'($urandom_range(0, 255)) - 128;
    return p;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_rows(input blk_t p, input int nrows, input int max_gap);
    logic [63:0] d;
    int          v, gap;
    for (int r = 0; r < nrows; r++) begin
      for (int k = 0; k < 8; k++) begin
        v = p[r][k];
        d[8*k +: 8] = v[7:0];
      end
      bus.BD_inputready = 1'b1;
      bus.BD_readdata   = d;
      last_edge = cyc + 1;
      @(posedge clk); #1;
      bus.BD_inputready = 1'b0;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    int t = 0;
    while (got_w.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    ok = (got_w.size() >= n);
    repeat (25) begin @(posedge clk); #1; end
  endtask

  function automatic void clear_log();
    got_w.delete();
    got_c.delete();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.BD_inputready = 1'b0;
    bus.BD_readdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.BD_outputready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.BD_outputready);
    else n_pass++;
    n_checks++;
    if (bus.BD_writedata !== 128'd0) $display("FAIL reset_data: got %h want 0", bus.BD_writedata);
    else n_pass++;
    reset = 1'b0;
    clear_log();
    repeat (20) begin @(posedge clk); #1; end
    n_checks++;
    if (got_w.size() !== 0) $display("FAIL idle_no_output: got %0d words want 0", got_w.size());
    else n_pass++;
    n_checks++;
    if (bus.BD_writedata !== 128'd0) $display("FAIL idle_data: got %h want 0", bus.BD_writedata);
    else n_pass++;
  endtask

  task automatic test_zero_block();
    blk_t p, c;
    bit   ok;
    p = const_blk(0);
    model2d(p, c);
    clear_log();
    send_rows(p, 8, 0);
    wait_words(8, ok);
    n_checks++;
    if (!ok || got_w.size() != 8) $display("FAIL zero_count: got %0d words want 8", got_w.size());
    else n_pass++;
    for (int j = 0; j < 8 && j < got_w.size(); j++) begin
      n_checks++;
      if (got_w[j] !== exp_word(c, j)) $display("FAIL zero_word%0d: got %h want %h", j, got_w[j], exp_word(c, j));
      else n_pass++;
      n_checks++;
      if (got_c[j] != last_edge + 7 + j)
        $display("FAIL zero_timing%0d: got cycle %0d want %0d", j, got_c[j], last_edge + 7 + j);
      else n_pass++;
    end
  endtask

  task automatic test_dc_block();
    blk_t p, c;
    bit   ok;
    p = const_blk(10);
    model2d(p, c);
    clear_log();
    send_rows(p, 8, 0);
    wait_words(8, ok);
    n_checks++;
    if (!ok || got_w.size() != 8) $display("FAIL dc_count: got %0d words want 8", got_w.size());
    else n_pass++;
    if (got_w.size() > 0) begin
      n_checks++;
      if (lane(got_w[0], 0) != 640) $display("FAIL dc_value: got %0d want 640", lane(got_w[0], 0));
      else n_pass++;
    end
    for (int j = 0; j < 8 && j < got_w.size(); j++) begin
      n_checks++;
      if (got_w[j] !== exp_word(c, j)) $display("FAIL dc_word%0d: got %h want %h", j, got_w[j], exp_word(c, j));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    blk_t p1, p2, c1, c2;
    bit   ok;
    int   first_edge;
    p1 = const_blk(-128);
    p2 = const_blk(127);
    model2d(p1, c1);
    model2d(p2, c2);
    clear_log();
    send_rows(p1, 8, 0);
    first_edge = last_edge;
    send_rows(p2, 8, 0);
    wait_words(16, ok);
    n_checks++;
    if (!ok || got_w.size() != 16) $display("FAIL b2b_count: got %0d words want 16", got_w.size());
    else n_pass++;
    if (got_w.size() == 16) begin
      n_checks++;
      if (lane(got_w[0], 0) != -8192) $display("FAIL b2b_min_dc: got %0d want -8192", lane(got_w[0], 0));
      else n_pass++;
      n_checks++;
      if (lane(got_w[8], 0) != 8128) $display("FAIL b2b_max_dc: got %0d want 8128", lane(got_w[8], 0));
      else n_pass++;
      n_checks++;
      if (got_c[0] != first_edge + 7) $display("FAIL b2b_first_time: got %0d want %0d", got_c[0], first_edge + 7);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (got_w[i] !== ((i < 8) ? exp_word(c1, i) : exp_word(c2, i - 8)))
          $display("FAIL b2b_word%0d: got %h want %h", i, got_w[i], (i < 8) ? exp_word(c1, i) : exp_word(c2, i - 8));
        else n_pass++;
        n_checks++;
        if (got_c[i] != got_c[0] + i) $display("FAIL b2b_gapless%0d: got cycle %0d want %0d", i, got_c[i], got_c[0] + i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_gaps();
    blk_t p1, p2, c1, c2;
    bit   ok;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) p1[r][k] = k;
    p2 = rand_blk();
    model2d(p1, c1);
    model2d(p2, c2);
    clear_log();
    send_rows(p1, 8, 5);
    send_rows(p2, 8, 5);
    wait_words(16, ok);
    n_checks++;
    if (!ok || got_w.size() != 16) $display("FAIL gaps_count: got %0d words want 16", got_w.size());
    else n_pass++;
    if (got_w.size() == 16) begin
      n_checks++;
      if (got_c[15] != last_edge + 14) $display("FAIL gaps_last_time: got %0d want %0d", got_c[15], last_edge + 14);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (got_w[i] !== ((i < 8) ? exp_word(c1, i) : exp_word(c2, i - 8)))
          $display("FAIL gaps_word%0d: got %h want %h", i, got_w[i], (i < 8) ? exp_word(c1, i) : exp_word(c2, i - 8));
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_block_reset();
    blk_t pj, p, c;
    bit   ok;
    pj = rand_blk();
    p  = const_blk(10);
    model2d(p, c);
    send_rows(pj, 4, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.BD_outputready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", bus.BD_outputready);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_log();
    send_rows(p, 8, 0);
    wait_words(8, ok);
    n_checks++;
    if (!ok || got_w.size() != 8) $display("FAIL midrst_count: got %0d words want 8", got_w.size());
    else n_pass++;
    if (got_w.size() > 0) begin
      n_checks++;
      if (lane(got_w[0], 0) != 640) $display("FAIL midrst_dc: got %0d want 640", lane(got_w[0], 0));
      else n_pass++;
    end
    for (int j = 0; j < 8 && j < got_w.size(); j++) begin
      n_checks++;
      if (got_w[j] !== exp_word(c, j)) $display("FAIL midrst_word%0d: got %h want %h", j, got_w[j], exp_word(c, j));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_dc_block();
    test_back_to_back();
    test_random_gaps();
    test_random_gaps();
    test_mid_block_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
